ctrl_lancer: RTL and testbench

- Roll sequencer for the dice datapath. It consumes the die bounds produced by the die-type selector (`min_de`, `faces_de`) and a debounced "roll" button.
- It runs a free-cycling die counter, animates the displayed value while the button is held, and latches 1–4 dice results on and after release.
- It accumulates the dice into a sum for the 7-segment display path and flags completion.

---
 rtl/ctrl_lancer.sv | 147 ++++++++++++++
 tb/tb_ctrl_lancer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_lancer.sv
// Roll sequencer for the dice datapath: free-running die counter, animated
// display while the button is held, then 1..NB_MAX dice latched DELAI cycles
// apart after release, accumulated into a sum with a completion pulse.
module ctrl_lancer #(
    parameter int DIV_ANIM = 2500000,
    parameter int DELAI    = 5000000,
    parameter int NB_MAX   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lancer,
    input  logic [2:0] nb_des,
    input  logic [6:0] min_de,
    input  logic [6:0] faces_de,
    output logic [6:0] valeur_de,
    output logic [8:0] somme,
    output logic [2:0] num_de,
    output logic       occupe,
    output logic       pret
);

    localparam int DIV_W = (DIV_ANIM > 1) ? $clog2(DIV_ANIM) : 1;
    localparam int AT_W  = (DELAI > 1) ? $clog2(DELAI) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_ANIM - 1);
    localparam logic [AT_W-1:0]  AT_INIT  = AT_W'(DELAI - 1);
    localparam logic [2:0]       NB_LIM   = 3'(NB_MAX);

    typedef enum logic [1:0] {
        REPOS  = 2'd0,
        ROULE  = 2'd1,
        TIRAGE = 2'd2,
        FINI   = 2'd3
    } state_t;

    state_t           state_q;
    logic [6:0]       cnt_q, cnt_d;
    logic [6:0]       min_q, faces_q;
    logic [2:0]       nb_q;
    logic [DIV_W-1:0] div_q;
    logic [AT_W-1:0]  attente_q;
    logic [6:0]       valeur_q;
    logic [8:0]       somme_q;
    logic [2:0]       num_q;
    logic             pret_q;
    logic             lancer_prec_q;

    logic [6:0] lo, hi;
    logic [2:0] nb_clamp;
    logic       rise;

    // Die bounds: live while idle, frozen copies for the whole roll.
    always_comb begin
        lo       = (state_q == REPOS) ? min_de   : min_q;
        hi       = (state_q == REPOS) ? faces_de : faces_q;
        cnt_d    = (cnt_q < lo || cnt_q >= hi) ? lo : cnt_q + 7'd1;
        nb_clamp = (nb_des == 3'd0) ? 3'd1 : ((nb_des > NB_LIM) ? NB_LIM : nb_des);
        rise     = lancer & ~lancer_prec_q;
    end

    // Free-running die counter, cycles min..faces in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 7'd0;
        else          cnt_q <= cnt_d;
    end

    // Roll FSM with registered outputs; pret is high exactly during FINI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= REPOS;
            min_q         <= 7'd0;
            faces_q       <= 7'd0;
            nb_q          <= 3'd0;
            div_q         <= '0;
            attente_q     <= '0;
            valeur_q      <= 7'd0;
            somme_q       <= 9'd0;
            num_q         <= 3'd0;
            pret_q        <= 1'b0;
            lancer_prec_q <= 1'b0;
        end else begin
            lancer_prec_q <= lancer;
            pret_q        <= 1'b0;
            case (state_q)
                REPOS: begin
                    if (rise) begin
                        state_q <= ROULE;
                        min_q   <= min_de;
                        faces_q <= faces_de;
                        nb_q    <= nb_clamp;
                        somme_q <= 9'd0;
                        num_q   <= 3'd0;
                        div_q   <= '0;
                    end
                end
                ROULE: begin
                    if (lancer) begin
                        // Animation: refresh the display every DIV_ANIM cycles.
                        if (div_q == DIV_LAST) begin
                            div_q    <= '0;
                            valeur_q <= cnt_q;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end else begin
                        // Release: first die is the counter value right now.
                        valeur_q <= cnt_q;
                        somme_q  <= {2'b00, cnt_q};
                        num_q    <= 3'd1;
                        if (nb_q == 3'd1) begin
                            state_q <= FINI;
                            pret_q  <= 1'b1;
                        end else begin
                            attente_q <= AT_INIT;
                            state_q   <= TIRAGE;
                        end
                    end
                end
                TIRAGE: begin
                    if (attente_q != '0) begin
                        attente_q <= attente_q - AT_W'(1);
                    end else begin
                        valeur_q <= cnt_q;
                        somme_q  <= somme_q + {2'b00, cnt_q};
                        num_q    <= num_q + 3'd1;
                        if (num_q + 3'd1 == nb_q) begin
                            state_q <= FINI;
                            pret_q  <= 1'b1;
                        end else begin
                            attente_q <= AT_INIT;
                        end
                    end
                end
                FINI: begin
                    state_q <= REPOS;
                end
                default: state_q <= REPOS;
            endcase
        end
    end

    assign valeur_de = valeur_q;
    assign somme     = somme_q;
    assign num_de    = num_q;
    assign pret      = pret_q;
    assign occupe    = (state_q == ROULE) || (state_q == TIRAGE);

endmodule

// File: tb/tb_ctrl_lancer.sv
// Scoreboard bench for ctrl_lancer: stimulus pushes the expected result of
// each roll, a negedge monitor pops and checks it whenever pret pulses.
module tb_ctrl_lancer;

    localparam int DIV_ANIM = 3;
    localparam int DELAI    = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lancer = 1'b0;
    logic [2:0] nb_des = 3'd1;
    logic [6:0] min_de = 7'd1;
    logic [6:0] faces_de = 7'd6;
    logic [6:0] valeur_de;
    logic [8:0] somme;
    logic [2:0] num_de;
    logic       occupe;
    logic       pret;

    ctrl_lancer #(.DIV_ANIM(DIV_ANIM), .DELAI(DELAI), .NB_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n), .lancer(lancer), .nb_des(nb_des),
        .min_de(min_de), .faces_de(faces_de), .valeur_de(valeur_de),
        .somme(somme), .num_de(num_de), .occupe(occupe), .pret(pret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int sum;
        int num;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference die counter built from the bounds rule.
    logic [6:0] m_cnt;
    logic [6:0] m_lo = 7'd0, m_hi = 7'd0;
    bit         m_busy = 1'b0;

    function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo, input logic [6:0] hi);
        return (v < lo || v >= hi) ? lo : v + 7'd1;
    endfunction

    function automatic logic [6:0] adv(input logic [6:0] v, input int n, input logic [6:0] lo, input logic [6:0] hi);
        logic [6:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = step(r, lo, hi);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_cnt <= 7'd0;
        else          m_cnt <= step(m_cnt, m_busy ? m_lo : min_de, m_busy ? m_hi : faces_de);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic press();
        edges(1);
        m_lo   = min_de;
        m_hi   = faces_de;
        m_busy = 1'b1;
        lancer = 1'b1;
    endtask

    // Release when the counter is about to sample target (target<0: now).
    // exp_sum<0 means the expected dice are derived from the counter rule.
    task automatic release_roll(input int target, input int n, input int exp_val,
                                input int exp_sum, input bit push);
        exp_t e;
        logic [6:0] d;
        int s;
        if (target >= 0) begin
            for (int i = 0; i < 20 && m_cnt != 7'(target); i++) edges(1);
            chk("release_target", int'(m_cnt), target);
        end
        lancer = 1'b0;
        d = m_cnt;
        s = int'(d);
        for (int k = 1; k < n; k++) begin
            d = adv(d, DELAI, m_lo, m_hi);
            s += int'(d);
        end
        e.val = (exp_sum < 0) ? int'(d) : exp_val;
        e.sum = (exp_sum < 0) ? s : exp_sum;
        e.num = n;
        e.cyc = cyc + 1 + (n - 1) * DELAI;
        if (push) exp_q.push_back(e);
    endtask

    // Run out to just after the FINI cycle, then model leaves roll mode.
    task automatic finish(input int n, input int already);
        edges(2 + (n - 1) * DELAI - already);
        m_busy = 1'b0;
    endtask

    // Monitor: every pret pulse must match the oldest pending roll.
    bit pret_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_n && pret) begin
            exp_t e;
            chk("pret_width", int'(pret_prev), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pret", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("valeur_de", int'(valeur_de), e.val);
                chk("somme", int'(somme), e.sum);
                chk("num_de", int'(num_de), e.num);
                chk("pret_cycle", cyc, e.cyc);
                chk("occupe_at_pret", int'(occupe), 0);
            end
        end
        pret_prev = pret;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        // Reset state
        #12;
        chk("rst_valeur", int'(valeur_de), 0);
        chk("rst_somme", int'(somme), 0);
        chk("rst_num", int'(num_de), 0);
        chk("rst_occupe", int'(occupe), 0);
        chk("rst_pret", int'(pret), 0);
        edges(1);
        reset_n = 1'b1;

        // Idle: counter runs, outputs stay cleared
        for (int i = 0; i < 5; i++) begin
            edges(1);
            chk("idle_outputs", int'({valeur_de, somme, num_de, occupe, pret}), 0);
        end

        // d6, one die, animation then release at 4
        nb_des = 3'd1;
        press();
        c0 = int'(m_cnt);
        edges(4);
        chk("anim_valeur", int'(valeur_de), int'(adv(7'(c0), 3, 7'd1, 7'd6)));
        chk("occupe_roule", int'(occupe), 1);
        edges(3);
        release_roll(4, 1, 4, 4, 1'b1);
        finish(1, 0);

        // d6, three dice: 4, 6, 2
        nb_des = 3'd3;
        press();
        edges(7);
        release_roll(4, 3, 2, 12, 1'b1);
        edges(5);
        chk("occupe_tirage", int'(occupe), 1);
        finish(3, 5);

        // Bounds change mid-roll is ignored: 1, 3, 5
        press();
        edges(4);
        release_roll(1, 3, 5, 9, 1'b1);
        edges(4);
        min_de = 7'd0;
        faces_de = 7'd99;
        finish(3, 4);
        // New bounds now apply
        nb_des = 3'd1;
        press();
        edges(4);
        release_roll(-1, 1, 0, -1, 1'b1);
        finish(1, 0);
        min_de = 7'd1;
        faces_de = 7'd6;

        // nb_des=0 acts as one die
        nb_des = 3'd0;
        press();
        edges(3);
        release_roll(2, 1, 2, 2, 1'b1);
        finish(1, 0);

        // nb_des=7 clamps to four: 6, 2, 4, 6; button re-held through FINI
        nb_des = 3'd7;
        press();
        edges(3);
        release_roll(6, 4, 6, 18, 1'b1);
        edges(3);
        lancer = 1'b1;
        finish(4, 3);
        for (int i = 0; i < 5; i++) begin
            edges(1);
            chk("held_no_retrigger", int'(occupe), 0);
        end
        lancer = 1'b0;
        edges(1);
        nb_des = 3'd2;
        press();
        edges(3);
        release_roll(3, 2, 5, 8, 1'b1);
        finish(2, 0);

        // Degenerate die 3..3, four dice
        min_de = 7'd3;
        faces_de = 7'd3;
        nb_des = 3'd4;
        edges(2);
        press();
        edges(3);
        release_roll(3, 4, 3, 12, 1'b1);
        finish(4, 0);
        min_de = 7'd1;
        faces_de = 7'd6;
        edges(2);

        // Reset mid-TIRAGE aborts without pret: dice 5, 1 so far
        nb_des = 3'd3;
        press();
        edges(3);
        release_roll(5, 3, 0, 0, 1'b0);
        edges(1 + DELAI);
        chk("mid_somme", int'(somme), 6);
        chk("mid_num", int'(num_de), 2);
        chk("mid_occupe", int'(occupe), 1);
        reset_n = 1'b0;
        m_busy = 1'b0;
        #1;
        chk("abort_outputs", int'({valeur_de, somme, num_de, occupe, pret}), 0);
        edges(2);
        reset_n = 1'b1;
        edges(3);
        nb_des = 3'd2;
        press();
        edges(3);
        release_roll(2, 2, 4, 6, 1'b1);
        finish(2, 0);
        edges(3);

        chk("pending_rolls", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
